// File: rtl/invader_fleet_pkg.sv
// Shared constants for the invader fleet: formation geometry, playfield bounds,
// FSM state encoding and the hit-index to row helper.
package invader_fleet_pkg;

  localparam int INVADERS_H        = 11;
  localparam int INVADERS_V        = 5;
  localparam int INVADERS_N        = INVADERS_H * INVADERS_V;
  localparam int INVADERS_OFFSET_H = 40;
  localparam int INVADERS_OFFSET_V = 32;
  localparam int SPRITE_W          = 24;
  localparam int SPRITE_H          = 16;
  localparam int START_X           = 64;
  localparam int START_Y           = 48;
  localparam int STEP_X            = 4;
  localparam int STEP_Y            = 16;
  localparam int BOUND_LEFT        = 16;
  localparam int BOUND_RIGHT       = 624;
  localparam int BOUND_BOTTOM      = 416;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_CLEARED = 2'd2;
  localparam logic [1:0] ST_LANDED  = 2'd3;

  // Row of a zero-based invader bit index (0..54).
  function automatic logic [2:0] hit_row(input logic [5:0] bit_idx);
    if (bit_idx < 6'd11)      return 3'd0;
    else if (bit_idx < 6'd22) return 3'd1;
    else if (bit_idx < 6'd33) return 3'd2;
    else if (bit_idx < 6'd44) return 3'd3;
    else                      return 3'd4;
  endfunction

endpackage

// File: rtl/invader_fleet_extent.sv
// Combinational extents of the alive mask: leftmost/rightmost occupied column,
// lowest occupied row, and whether anything is alive at all.
module fleet_extent
  import invader_fleet_pkg::*;
(
  input  logic [54:0] i_mask,
  output logic [3:0]  o_lcol,
  output logic [3:0]  o_rcol,
  output logic [2:0]  o_brow,
  output logic        o_any
);

  logic [10:0] w_col_any;
  logic [4:0]  w_row_any;

  always_comb begin
    w_col_any = '0;
    w_row_any = '0;
    for (int unsigned r = 0; r < INVADERS_V; r++) begin
      for (int unsigned c = 0; c < INVADERS_H; c++) begin
        if (i_mask[r*INVADERS_H + c]) begin
          w_col_any[c] = 1'b1;
          w_row_any[r] = 1'b1;
        end
      end
    end

    o_lcol = '0;
    o_rcol = '0;
    o_brow = '0;
    // Ascending scan keeps the last hit for rcol/brow; descending scan gives lcol.
    for (int unsigned c = 0; c < INVADERS_H; c++) begin
      if (w_col_any[c]) o_rcol = 4'(c);
      if (w_col_any[INVADERS_H-1-c]) o_lcol = 4'(INVADERS_H-1-c);
    end
    for (int unsigned r = 0; r < INVADERS_V; r++) begin
      if (w_row_any[r]) o_brow = 3'(r);
    end
    o_any = |i_mask;
  end

endmodule

// File: rtl/invader_fleet.sv
// Invader formation controller: alive mask, frame-paced marching, descent on
// edge contact, collision kills and CLEARED/LANDED end states.
module invader_fleet
  import invader_fleet_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic        start,
  input  logic [5:0]  invader_collision,
  output logic [54:0] invaders,
  output logic [9:0]  invaders_x,
  output logic [9:0]  invaders_y,
  output logic        anim,
  output logic        kill,
  output logic [2:0]  kill_row,
  output logic        cleared,
  output logic        landed
);

  logic [1:0]  r_state;
  logic [54:0] r_mask;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_dir_right;
  logic        r_anim;
  logic        r_kill;
  logic [2:0]  r_kill_row;
  logic [5:0]  r_alive;
  logic [3:0]  r_cnt;

  logic [3:0]  w_lcol;
  logic [3:0]  w_rcol;
  logic [2:0]  w_brow;
  logic        w_any;

  fleet_extent u_extent (
    .i_mask (r_mask),
    .o_lcol (w_lcol),
    .o_rcol (w_rcol),
    .o_brow (w_brow),
    .o_any  (w_any)
  );

  logic [5:0]  w_bit;
  logic        w_valid;
  logic [54:0] w_onehot;
  logic        w_hit;
  logic        w_last_kill;
  logic [3:0]  w_period;
  logic        w_step;
  logic [10:0] w_right;
  logic [10:0] w_left;
  logic        w_turn;
  logic [9:0]  w_x_next;
  logic [9:0]  w_y_next;
  logic [10:0] w_bottom;
  logic        w_land;

  assign w_bit       = invader_collision - 6'd1;
  assign w_valid     = (invader_collision != 6'd0) && (invader_collision <= 6'(INVADERS_N));
  assign w_onehot    = {54'd0, 1'b1} << w_bit;
  assign w_hit       = w_valid && |(r_mask & w_onehot);
  assign w_last_kill = w_hit && (r_alive == 6'd1);

  // Extents and period come from the pre-kill mask/count, so a kill and a
  // step in the same cycle see the formation as it was at the frame start.
  assign w_period = 4'd1 + r_alive[5:2];
  assign w_step   = w_any && (r_cnt >= w_period - 4'd1);

  assign w_right  = 11'(r_x) + 11'(w_rcol) * 11'(INVADERS_OFFSET_H) + 11'(SPRITE_W);
  assign w_left   = 11'(r_x) + 11'(w_lcol) * 11'(INVADERS_OFFSET_H);
  assign w_turn   = r_dir_right ? (w_right + 11'(STEP_X) > 11'(BOUND_RIGHT))
                                : (w_left < 11'(BOUND_LEFT + STEP_X));
  assign w_x_next = w_turn ? r_x : (r_dir_right ? r_x + 10'(STEP_X) : r_x - 10'(STEP_X));
  assign w_y_next = w_turn ? r_y + 10'(STEP_Y) : r_y;
  assign w_bottom = 11'(w_y_next) + 11'(w_brow) * 11'(INVADERS_OFFSET_V) + 11'(SPRITE_H);
  assign w_land   = w_bottom >= 11'(BOUND_BOTTOM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_x         <= 10'(START_X);
      r_y         <= 10'(START_Y);
      r_dir_right <= 1'b1;
      r_anim      <= 1'b0;
      r_kill      <= 1'b0;
      r_kill_row  <= '0;
      r_alive     <= '0;
      r_cnt       <= '0;
    end else begin
      r_kill <= 1'b0;
      if (start) begin
        r_state     <= ST_RUN;
        r_mask      <= '1;
        r_x         <= 10'(START_X);
        r_y         <= 10'(START_Y);
        r_dir_right <= 1'b1;
        r_anim      <= 1'b0;
        r_alive     <= 6'(INVADERS_N);
        r_cnt       <= '0;
      end else if (r_state == ST_RUN) begin
        if (r_alive == '0) begin
          r_state <= ST_CLEARED;
        end else begin
          if (w_hit) begin
            r_mask     <= r_mask & ~w_onehot;
            r_kill     <= 1'b1;
            r_kill_row <= hit_row(w_bit);
            r_alive    <= r_alive - 6'd1;
          end
          if (frame) begin
            if (w_step) begin
              r_cnt       <= '0;
              r_x         <= w_x_next;
              r_y         <= w_y_next;
              r_dir_right <= r_dir_right ^ w_turn;
              r_anim      <= ~r_anim;
              // A simultaneous last kill leaves RUN for CLEARED instead.
              if (w_land && !w_last_kill) r_state <= ST_LANDED;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
      end
    end
  end

  assign invaders   = r_mask;
  assign invaders_x = r_x;
  assign invaders_y = r_y;
  assign anim       = r_anim;
  assign kill       = r_kill;
  assign kill_row   = r_kill_row;
  assign cleared    = (r_state == ST_CLEARED);
  assign landed     = (r_state == ST_LANDED);

endmodule

// File: tb/tb_invader_fleet.sv
// Bench for invader_fleet: an abstract per-cycle model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_invader_fleet;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  invader_collision = '0;
  logic [54:0] invaders;
  logic [9:0]  invaders_x;
  logic [9:0]  invaders_y;
  logic        anim;
  logic        kill;
  logic [2:0]  kill_row;
  logic        cleared;
  logic        landed;

  invader_fleet dut (
    .clk               (clk),
    .rst               (rst),
    .frame             (frame),
    .start             (start),
    .invader_collision (invader_collision),
    .invaders          (invaders),
    .invaders_x        (invaders_x),
    .invaders_y        (invaders_y),
    .anim              (anim),
    .kill              (kill),
    .kill_row          (kill_row),
    .cleared           (cleared),
    .landed            (landed)
  );

  always #5 clk = ~clk;

  // mode: 0 idle, 1 marching, 2 cleared, 3 landed
  typedef struct {
    logic [54:0] mask;
    int          x;
    int          y;
    bit          right;
    bit          anim;
    bit          kill;
    int          krow;
    int          mode;
    int          cnt;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.mask = '0; r.x = 64; r.y = 48; r.right = 1'b1; r.anim = 1'b0;
    r.kill = 1'b0; r.krow = 0; r.mode = 0; r.cnt = 0;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, logic st, logic fr, logic [5:0] col);
    model_t n;
    int alive, lc, rc, br, p, ci;
    n = c;
    n.kill = 1'b0;
    ci = int'(col);
    if (st) begin
      n.mask = '1; n.x = 64; n.y = 48; n.right = 1'b1; n.anim = 1'b0;
      n.mode = 1; n.cnt = 0;
    end else if (c.mode == 1) begin
      alive = $countones(c.mask);
      if (alive == 0) begin
        n.mode = 2;
      end else begin
        lc = 99; rc = -1; br = -1;
        for (int r = 0; r < 5; r++)
          for (int k = 0; k < 11; k++)
            if (c.mask[11*r + k]) begin
              if (k < lc) lc = k;
              if (k > rc) rc = k;
              if (r > br) br = r;
            end
        p = 1 + alive / 4;
        if (ci >= 1 && ci <= 55) begin
          if (c.mask[ci-1]) begin
            n.mask[ci-1] = 1'b0;
            n.kill = 1'b1;
            n.krow = (ci - 1) / 11;
          end
        end
        if (fr) begin
          if (c.cnt >= p - 1) begin
            n.cnt = 0;
            n.anim = !c.anim;
            if (c.right) begin
              if (c.x + 40*rc + 24 + 4 > 624) begin n.y = c.y + 16; n.right = 1'b0; end
              else n.x = c.x + 4;
            end else begin
              if (c.x + 40*lc < 20) begin n.y = c.y + 16; n.right = 1'b1; end
              else n.x = c.x - 4;
            end
            if (n.y + 32*br + 16 >= 416 && $countones(n.mask) != 0) n.mode = 3;
          end else begin
            n.cnt = c.cnt + 1;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_next(m, start, frame, invader_collision);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_invaders", 64'(invaders), 64'(m.mask));
    chk("m_x", 64'(invaders_x), 64'(m.x));
    chk("m_y", 64'(invaders_y), 64'(m.y));
    chk("m_anim", 64'(anim), 64'(m.anim));
    chk("m_kill", 64'(kill), 64'(m.kill));
    chk("m_kill_row", 64'(kill_row), 64'(m.krow));
    chk("m_cleared", 64'(cleared), 64'(m.mode == 2));
    chk("m_landed", 64'(landed), 64'(m.mode == 3));
  end

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk) frame = 1'b1;
      @(negedge clk) frame = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  int kills;
  int row_seen;
  int budget;
  int col10[5] = '{11, 22, 33, 44, 55};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_invaders", 64'(invaders), 64'd0);
    chk("rst_x", 64'(invaders_x), 64'd64);
    chk("rst_y", 64'(invaders_y), 64'd48);
    chk("rst_flags", {61'd0, cleared, landed, kill}, 64'd0);
    @(negedge clk) rst = 1'b0;

    // First march step lands on the 14th frame with a full fleet.
    pulse_start();
    chk("start_mask", 64'($countones(invaders)), 64'd55);
    frames(13);
    chk("f13_x", 64'(invaders_x), 64'd64);
    frames(1);
    chk("f14_x", 64'(invaders_x), 64'd68);
    chk("f14_anim", 64'(anim), 64'd1);
    chk("f14_y", 64'(invaders_y), 64'd48);

    frames(14*33);
    chk("step34_x", 64'(invaders_x), 64'd200);
    chk("step34_y", 64'(invaders_y), 64'd48);
    frames(14);
    chk("step35_y", 64'(invaders_y), 64'd64);
    chk("step35_x", 64'(invaders_x), 64'd200);
    frames(14);
    chk("step36_x_left", 64'(invaders_x), 64'd196);

    // Held collision level produces a single kill.
    @(negedge clk) invader_collision = 6'd12;
    kills = 0; row_seen = -1;
    repeat (500) begin
      @(negedge clk);
      if (kill) begin kills++; row_seen = int'(kill_row); end
    end
    invader_collision = 6'd0;
    chk("hold12_kills", 64'(kills), 64'd1);
    chk("hold12_row", 64'(row_seen), 64'd1);
    chk("hold12_bit11", 64'(invaders[11]), 64'd0);
    chk("hold12_alive", 64'($countones(invaders)), 64'd54);

    // Column 10 removed: turn happens at x=240.
    pulse_start();
    foreach (col10[i]) begin
      @(negedge clk) invader_collision = 6'(col10[i]);
    end
    @(negedge clk) invader_collision = 6'd0;
    budget = 2000;
    while (invaders_y == 10'd48 && budget > 0) begin
      frames(1);
      budget--;
    end
    chk("col10_budget", 64'(budget > 0), 64'd1);
    chk("col10_turn_x", 64'(invaders_x), 64'd240);
    chk("col10_turn_y", 64'(invaders_y), 64'd64);

    // Kill everything: cleared one cycle after the last kill.
    pulse_start();
    for (int i = 1; i <= 55; i++) begin
      @(negedge clk) invader_collision = 6'(i);
    end
    @(negedge clk);
    chk("clr_last_kill", 64'(kill), 64'd1);
    chk("clr_not_yet", 64'(cleared), 64'd0);
    invader_collision = 6'd0;
    @(negedge clk);
    chk("clr_cleared", 64'(cleared), 64'd1);
    chk("clr_empty", 64'(invaders), 64'd0);
    frames(30);
    chk("clr_frozen_x", 64'(invaders_x), 64'd64);
    chk("clr_still", 64'(cleared), 64'd1);

    // Start coincident with a collision: start wins.
    @(negedge clk) begin start = 1'b1; invader_collision = 6'd7; end
    @(negedge clk) begin start = 1'b0; invader_collision = 6'd0; end
    chk("restart_alive", 64'($countones(invaders)), 64'd55);
    chk("restart_x", 64'(invaders_x), 64'd64);
    chk("restart_kill", 64'(kill), 64'd0);
    chk("restart_cleared", 64'(cleared), 64'd0);

    // Full fleet marches down until the bottom row reaches 416.
    budget = 30000;
    while (!landed && budget > 0) begin
      frames(1);
      budget--;
    end
    chk("land_budget", 64'(budget > 0), 64'd1);
    chk("land_flag", 64'(landed), 64'd1);
    chk("land_y", 64'(invaders_y), 64'd272);
    frames(20);
    chk("land_y_frozen", 64'(invaders_y), 64'd272);
    chk("land_mask", 64'($countones(invaders)), 64'd55);

    // Asynchronous reset mid-run with a collision pending.
    pulse_start();
    frames(20);
    @(negedge clk) invader_collision = 6'd5;
    #1 rst = 1'b1;
    #1;
    chk("arst_invaders", 64'(invaders), 64'd0);
    chk("arst_x", 64'(invaders_x), 64'd64);
    chk("arst_y", 64'(invaders_y), 64'd48);
    chk("arst_misc", {58'd0, anim, kill, kill_row, cleared, landed} >> 0, 64'd0);
    kills = 0;
    repeat (4) begin
      @(negedge clk);
      if (kill) kills++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (kill) kills++;
    end
    invader_collision = 6'd0;
    chk("arst_no_kill", 64'(kills), 64'd0);
    frames(30);
    chk("arst_idle_x", 64'(invaders_x), 64'd64);
    chk("arst_idle_mask", 64'(invaders), 64'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
